// File: rtl/result_mem_if_pkg.sv
// ============================================================================
// Module : result_mem_if_pkg
// Brief  : Shared state encoding and sizing constants for the result writer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package result_mem_if_pkg;

    localparam int ACC_W_DEF  = 16;
    localparam int N_MACS_DEF = 4;
    localparam int WORD_BYTES = N_MACS_DEF * ACC_W_DEF / 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/result_lane_buf.sv
// ============================================================================
// Module : result_lane_buf
// Brief  : Per-lane hold register and arrival flag, with optional ReLU.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module result_lane_buf
    import result_mem_if_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int RELU_EN = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear_i,
    input  logic                    capture_i,
    input  logic signed [ACC_W-1:0] acc_i,
    output logic        [ACC_W-1:0] hold_o,
    output logic        [ACC_W-1:0] hold_d_o,
    output logic                    flag_o,
    output logic                    flag_d_o,
    output logic                    overrun_o
);

    logic [ACC_W-1:0] hold_q;
    logic [ACC_W-1:0] hold_d;
    logic             flag_q;
    logic             flag_d;
    logic [ACC_W-1:0] w_val;

    always_comb begin
        w_val = acc_i;
        if (RELU_EN != 0 && acc_i[ACC_W-1]) begin
            w_val = '0;
        end
        hold_d = capture_i ? w_val : hold_q;
        // A fresh arrival must survive the row-complete clear in the same cycle.
        flag_d = capture_i | (flag_q & ~clear_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
            flag_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            flag_q <= flag_d;
        end
    end

    assign hold_o    = hold_q;
    assign hold_d_o  = hold_d;
    assign flag_o    = flag_q;
    assign flag_d_o  = flag_d;
    assign overrun_o = capture_i & flag_q & ~clear_i;

endmodule

`default_nettype wire

// File: rtl/result_mem_if.sv
// ============================================================================
// Module : result_mem_if
// Brief  : Gathers staggered MAC lane results into rows and writes them to BRAM.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module result_mem_if
    import result_mem_if_pkg::*;
#(
    parameter int ACC_W       = ACC_W_DEF,
    parameter int N_MACS      = N_MACS_DEF,
    parameter int BRAM_ADDR_W = 11,
    parameter int RELU_EN     = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [BRAM_ADDR_W-1:0]         base_addr,
    input  logic [7:0]                     num_rows,
    input  logic signed [ACC_W-1:0]        acc_in_0,
    input  logic signed [ACC_W-1:0]        acc_in_1,
    input  logic signed [ACC_W-1:0]        acc_in_2,
    input  logic signed [ACC_W-1:0]        acc_in_3,
    input  logic [N_MACS-1:0]              valid_in,
    output logic                           bram_en,
    output logic [N_MACS*ACC_W/8-1:0]      bram_we,
    output logic [BRAM_ADDR_W-1:0]         bram_addr,
    output logic [N_MACS*ACC_W-1:0]        bram_din,
    output logic                           busy,
    output logic                           done,
    output logic                           overrun
);

    localparam logic [BRAM_ADDR_W-1:0] ADDR_STEP = BRAM_ADDR_W'(N_MACS * ACC_W / 8);

    state_t                   state_q;
    logic [BRAM_ADDR_W-1:0]   addr_q;
    logic [7:0]               num_rows_q;
    logic [7:0]               row_cnt_q;

    logic signed [ACC_W-1:0]  w_acc    [N_MACS];
    logic [ACC_W-1:0]         w_hold   [N_MACS];
    logic [ACC_W-1:0]         w_hold_d [N_MACS];
    logic [N_MACS-1:0]        w_flag;
    logic [N_MACS-1:0]        w_flag_d;
    logic [N_MACS-1:0]        w_ovr;
    logic [N_MACS-1:0]        w_capture;
    logic                     w_clear;
    logic                     w_start_ok;
    logic                     w_collecting;
    logic [N_MACS*ACC_W-1:0]  w_din_d;

    assign w_acc[0] = acc_in_0;
    assign w_acc[1] = acc_in_1;
    assign w_acc[2] = acc_in_2;
    assign w_acc[3] = acc_in_3;

    assign w_start_ok   = start && (state_q == ST_IDLE);
    assign w_collecting = (state_q == ST_COLLECT) || (state_q == ST_WRITE);
    assign w_capture    = valid_in & {N_MACS{w_collecting}};
    assign w_clear      = (state_q == ST_WRITE) || w_start_ok;

    generate
        for (genvar i = 0; i < N_MACS; i++) begin : g_lane
            result_lane_buf #(
                .ACC_W   (ACC_W),
                .RELU_EN (RELU_EN)
            ) u_lane (
                .clk       (clk),
                .rst       (rst),
                .clear_i   (w_clear),
                .capture_i (w_capture[i]),
                .acc_i     (w_acc[i]),
                .hold_o    (w_hold[i]),
                .hold_d_o  (w_hold_d[i]),
                .flag_o    (w_flag[i]),
                .flag_d_o  (w_flag_d[i]),
                .overrun_o (w_ovr[i])
            );
            assign w_din_d[i*ACC_W +: ACC_W] = w_hold_d[i];
        end
    endgenerate

    // The registered write word uses the post-capture hold values, so a lane
    // arriving on the completing edge lands in the row written next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            num_rows_q <= '0;
            row_cnt_q  <= '0;
            bram_en    <= 1'b0;
            bram_we    <= '0;
            bram_addr  <= '0;
            bram_din   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            bram_en <= 1'b0;
            bram_we <= '0;
            done    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        overrun <= 1'b0;
                        if (num_rows != 8'd0) begin
                            addr_q     <= base_addr;
                            num_rows_q <= num_rows;
                            row_cnt_q  <= '0;
                            busy       <= 1'b1;
                            state_q    <= ST_COLLECT;
                        end else begin
                            done    <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (|w_ovr) begin
                        overrun <= 1'b1;
                    end
                    if (&w_flag_d) begin
                        bram_en   <= 1'b1;
                        bram_we   <= '1;
                        bram_addr <= addr_q;
                        bram_din  <= w_din_d;
                        state_q   <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    addr_q    <= addr_q + ADDR_STEP;
                    row_cnt_q <= row_cnt_q + 8'd1;
                    if (row_cnt_q + 8'd1 == num_rows_q) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_COLLECT;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_result_mem_if.sv
// ============================================================================
// Module : tb_result_mem_if
// Brief  : Scoreboard bench for result_mem_if (plain and ReLU instances).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_result_mem_if;
    import result_mem_if_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [10:0]        base_addr = '0;
    logic [7:0]         num_rows = '0;
    logic signed [15:0] acc0 = '0, acc1 = '0, acc2 = '0, acc3 = '0;
    logic [3:0]         valid_in = '0;

    logic        en0, busy0, done0, ovr0;
    logic [7:0]  we0;
    logic [10:0] addr0;
    logic [63:0] din0;
    logic        en1, busy1, done1, ovr1;
    logic [7:0]  we1;
    logic [10:0] addr1;
    logic [63:0] din1;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;

    typedef struct {
        logic [10:0] addr;
        logic [63:0] din;
    } wr_t;

    wr_t q0[$];
    wr_t q1[$];

    always #5 clk = ~clk;

    result_mem_if #(.RELU_EN(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_rows(num_rows),
        .acc_in_0(acc0), .acc_in_1(acc1), .acc_in_2(acc2), .acc_in_3(acc3),
        .valid_in(valid_in), .bram_en(en0), .bram_we(we0), .bram_addr(addr0),
        .bram_din(din0), .busy(busy0), .done(done0), .overrun(ovr0)
    );

    result_mem_if #(.RELU_EN(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_rows(num_rows),
        .acc_in_0(acc0), .acc_in_1(acc1), .acc_in_2(acc2), .acc_in_3(acc3),
        .valid_in(valid_in), .bram_en(en1), .bram_we(we1), .bram_addr(addr1),
        .bram_din(din1), .busy(busy1), .done(done1), .overrun(ovr1)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] relu(input logic [15:0] v);
        return v[15] ? 16'h0000 : v;
    endfunction

    task automatic push_row(input logic [10:0] a, input logic [15:0] l0, input logic [15:0] l1,
                            input logic [15:0] l2, input logic [15:0] l3);
        wr_t e;
        e.addr = a;
        e.din  = {l3, l2, l1, l0};
        q0.push_back(e);
        e.din  = {relu(l3), relu(l2), relu(l1), relu(l0)};
        q1.push_back(e);
    endtask

    // Write monitor: every BRAM enable must match the next expected row.
    always @(negedge clk) begin
        if (!rst) begin
            if (done0) n_done++;
            if (en0) begin
                if (q0.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_write0: addr %0h din %0h, no write expected", addr0, din0);
                end else begin
                    wr_t e;
                    e = q0.pop_front();
                    chk("wr0_addr", 64'(addr0), 64'(e.addr));
                    chk("wr0_din", din0, e.din);
                    chk("wr0_we", 64'(we0), 64'hFF);
                end
            end
            if (en1) begin
                if (q1.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_write1: addr %0h din %0h, no write expected", addr1, din1);
                end else begin
                    wr_t e;
                    e = q1.pop_front();
                    chk("wr1_addr", 64'(addr1), 64'(e.addr));
                    chk("wr1_din", din1, e.din);
                    chk("wr1_we", 64'(we1), 64'hFF);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [10:0] a, input logic [7:0] n);
        start = 1'b1; base_addr = a; num_rows = n;
        tick();
        start = 1'b0;
    endtask

    task automatic drive(input logic [3:0] v, input logic [15:0] a0, input logic [15:0] a1,
                         input logic [15:0] a2, input logic [15:0] a3);
        valid_in = v; acc0 = a0; acc1 = a1; acc2 = a2; acc3 = a3;
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        while (!done0 && k < 50) begin
            tick();
            k++;
        end
        chk(nm, 64'(done0), 64'd1);
        tick();
    endtask

    initial begin
        int d0;
        repeat (3) tick();
        chk("rst_en", 64'(en0), 0);
        chk("rst_we", 64'(we0), 0);
        chk("rst_addr", 64'(addr0), 0);
        chk("rst_din", din0, 0);
        chk("rst_busy", 64'(busy0), 0);
        chk("rst_done", 64'(done0), 0);
        chk("rst_ovr", 64'(ovr0), 0);
        rst = 1'b0;
        tick();

        // Basic staggered row
        push_row(11'h010, 16'd1, 16'd2, 16'd3, 16'd4);
        do_start(11'h010, 8'd1);
        chk("t1_busy", 64'(busy0), 1);
        drive(4'b0001, 16'd1, 16'd0, 16'd0, 16'd0); tick();
        drive(4'b0010, 16'd0, 16'd2, 16'd0, 16'd0); tick();
        drive(4'b0100, 16'd0, 16'd0, 16'd3, 16'd0); tick();
        drive(4'b1000, 16'd0, 16'd0, 16'd0, 16'd4); tick();
        drive(4'b0000, 16'd0, 16'd0, 16'd0, 16'd0);
        chk("t1_wr_cycle", 64'(en0), 1);
        tick();
        chk("t1_done", 64'(done0), 1);
        chk("t1_busy_end", 64'(busy0), 0);
        tick();
        chk("t1_done_pulse", 64'(done0), 0);

        // Back-to-back rows, next row arriving in the WRITE cycle
        d0 = n_done;
        push_row(11'h000, 16'd0, 16'd0, 16'd0, 16'd0);
        push_row(11'h008, 16'd1, 16'd1, 16'd1, 16'd1);
        push_row(11'h010, 16'd2, 16'd2, 16'd2, 16'd2);
        do_start(11'h000, 8'd3);
        drive(4'b1111, 16'd0, 16'd0, 16'd0, 16'd0); tick();
        drive(4'b1111, 16'd1, 16'd1, 16'd1, 16'd1); tick();
        drive(4'b0000, 16'd0, 16'd0, 16'd0, 16'd0); tick();
        drive(4'b1111, 16'd2, 16'd2, 16'd2, 16'd2); tick();
        drive(4'b0000, 16'd0, 16'd0, 16'd0, 16'd0); tick();
        wait_done("t2_done");
        chk("t2_ovr", 64'(ovr0), 0);
        chk("t2_done_once", 64'(n_done - d0), 1);

        // ReLU vs raw lanes
        push_row(11'h100, 16'hFFFB, 16'h0007, 16'hFFFF, 16'h0000);
        do_start(11'h100, 8'd1);
        drive(4'b1111, -16'sd5, 16'sd7, -16'sd1, 16'sd0); tick();
        drive(4'b0000, 16'd0, 16'd0, 16'd0, 16'd0);
        wait_done("t3_done");

        // Overrun on lane 0
        push_row(11'h020, 16'd11, 16'd1, 16'd2, 16'd3);
        do_start(11'h020, 8'd1);
        drive(4'b0001, 16'd9, 16'd0, 16'd0, 16'd0); tick();
        chk("t4_no_ovr_yet", 64'(ovr0), 0);
        drive(4'b0001, 16'd11, 16'd0, 16'd0, 16'd0); tick();
        chk("t4_ovr_set", 64'(ovr0), 1);
        drive(4'b1110, 16'd0, 16'd1, 16'd2, 16'd3); tick();
        drive(4'b0000, 16'd0, 16'd0, 16'd0, 16'd0);
        wait_done("t4_done");
        chk("t4_ovr_sticky", 64'(ovr0), 1);

        // Address wrap, then zero-row layer
        push_row(11'h7F8, 16'h000A, 16'h000B, 16'h000C, 16'h000D);
        push_row(11'h000, 16'h0010, 16'h0020, 16'h0030, 16'h0040);
        do_start(11'h7F8, 8'd2);
        chk("t5_ovr_clr", 64'(ovr0), 0);
        drive(4'b1111, 16'h000A, 16'h000B, 16'h000C, 16'h000D); tick();
        drive(4'b1111, 16'h0010, 16'h0020, 16'h0030, 16'h0040); tick();
        drive(4'b0000, 16'd0, 16'd0, 16'd0, 16'd0);
        wait_done("t5_done");
        do_start(11'h123, 8'd0);
        chk("t5_zero_done", 64'(done0), 1);
        chk("t5_zero_busy", 64'(busy0), 0);
        chk("t5_zero_en", 64'(en0), 0);
        tick();
        chk("t5_zero_pulse", 64'(done0), 0);

        // Reset mid-layer, then a new layer with a start-while-busy attempt
        do_start(11'h040, 8'd2);
        drive(4'b0011, 16'd5, 16'd6, 16'd0, 16'd0); tick();
        drive(4'b0000, 16'd0, 16'd0, 16'd0, 16'd0);
        rst = 1'b1; tick();
        rst = 1'b0;
        chk("t6_busy", 64'(busy0), 0);
        chk("t6_en", 64'(en0), 0);
        chk("t6_flag0", 64'(dut0.g_lane[0].u_lane.flag_q), 0);
        chk("t6_flag1", 64'(dut0.g_lane[1].u_lane.flag_q), 0);
        repeat (2) tick();
        push_row(11'h080, 16'h0011, 16'h0022, 16'h0033, 16'h0044);
        do_start(11'h080, 8'd1);
        drive(4'b0011, 16'h0011, 16'h0022, 16'd0, 16'd0);
        start = 1'b1; base_addr = 11'h300; num_rows = 8'd5;
        tick();
        start = 1'b0;
        drive(4'b1100, 16'd0, 16'd0, 16'h0033, 16'h0044); tick();
        drive(4'b0000, 16'd0, 16'd0, 16'd0, 16'd0);
        wait_done("t6_done");

        repeat (4) tick();
        chk("q0_drained", 64'(q0.size()), 0);
        chk("q1_drained", 64'(q1.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
